// File: rtl/dm_responder.sv
// Wait-stated data-memory responder: one request in flight, byte-lane stores,
// whole-word loads, and a registered commit-trace port for each store.
module dm_lane_merge (
  input  logic       en_i,
  input  logic [7:0] old_i,
  input  logic [7:0] new_i,
  output logic [7:0] out_o
);
  assign out_o = en_i ? new_i : old_i;
endmodule

module dm_responder #(
  parameter int DEPTH       = 4096,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy,
  output logic        trace_valid,
  output logic [31:0] trace_pc,
  output logic [31:0] trace_addr,
  output logic [31:0] trace_data
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q;
  logic [31:0] addr_q, wdata_q, pc_q;
  logic [3:0]  be_q;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        tv_q;
  logic [31:0] tpc_q, taddr_q, tdata_q;
  logic [31:0] mem_q [DEPTH];

  logic        accept, access, commit, from_in;
  logic        acc_we, be_ok, in_range, ok;
  logic [31:0] acc_addr, acc_wdata, acc_pc, old_word, merged;
  logic [3:0]  acc_be;
  logic [AW-1:0] widx;

  assign accept = req_valid && (state_q == S_IDLE);
  // With zero wait states the access happens on the accept edge itself,
  // so the operands come straight from the request bus in that case.
  assign access  = (accept && (WAIT_CYCLES == 0)) || ((state_q == S_WAIT) && (cnt_q <= 4'd1));
  assign from_in = (state_q == S_IDLE);
  assign acc_we    = from_in ? req_we    : we_q;
  assign acc_addr  = from_in ? req_addr  : addr_q;
  assign acc_be    = from_in ? req_be    : be_q;
  assign acc_wdata = from_in ? req_wdata : wdata_q;
  assign acc_pc    = from_in ? req_pc    : pc_q;

  always_comb begin
    be_ok = 1'b0;
    case (acc_be)
      4'b1111: be_ok = (acc_addr[1:0] == 2'd0);
      4'b0011: be_ok = (acc_addr[1:0] == 2'd0);
      4'b1100: be_ok = (acc_addr[1:0] == 2'd2);
      4'b0001: be_ok = (acc_addr[1:0] == 2'd0);
      4'b0010: be_ok = (acc_addr[1:0] == 2'd1);
      4'b0100: be_ok = (acc_addr[1:0] == 2'd2);
      4'b1000: be_ok = (acc_addr[1:0] == 2'd3);
      default: be_ok = 1'b0;
    endcase
  end

  assign in_range = ({2'b00, acc_addr[31:2]} < 32'(DEPTH));
  assign ok       = be_ok && in_range;
  assign widx     = acc_addr[AW+1:2];
  assign old_word = mem_q[widx];
  assign commit   = access && ok && acc_we;

  for (genvar l = 0; l < 4; l++) begin : g_lane
    dm_lane_merge u_lane (
      .en_i  (acc_be[l]),
      .old_i (old_word[8*l +: 8]),
      .new_i (acc_wdata[8*l +: 8]),
      .out_o (merged[8*l +: 8])
    );
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (accept) begin
        state_d = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
        cnt_d   = 4'(WAIT_CYCLES);
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = S_RESP;
      end
      S_RESP: if (resp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rdata_d = rdata_q;
    err_d   = err_q;
    if (access) begin
      rdata_d = (ok && !acc_we) ? old_word : 32'd0;
      err_d   = !ok;
    end else if ((state_q == S_RESP) && resp_ready) begin
      rdata_d = 32'd0;
      err_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (commit) begin
      mem_q[widx] <= merged;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      pc_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      tv_q    <= 1'b0;
      tpc_q   <= '0;
      taddr_q <= '0;
      tdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      tv_q    <= commit;
      if (accept) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        be_q    <= req_be;
        wdata_q <= req_wdata;
        pc_q    <= req_pc;
      end
      if (commit) begin
        tpc_q   <= acc_pc;
        taddr_q <= {acc_addr[31:2], 2'b00};
        tdata_q <= merged;
      end
    end
  end

  assign req_ready   = (state_q == S_IDLE);
  assign resp_valid  = (state_q == S_RESP);
  assign busy        = (state_q != S_IDLE);
  assign resp_rdata  = rdata_q;
  assign resp_err    = err_q;
  assign trace_valid = tv_q;
  assign trace_pc    = tpc_q;
  assign trace_addr  = taddr_q;
  assign trace_data  = tdata_q;
endmodule

// File: tb/tb_dm_responder.sv
// Bench for dm_responder: three instances (2, 0 and 3 wait states) driven by a
// directed table, hand sequences for backpressure/reset, and a random run vs a model.
module tb_dm_responder;
  localparam int DEPTH = 64;
  localparam int WC [3] = '{2, 0, 3};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst [3], rv [3], we [3], rr [3];
  logic [31:0] addr [3], wd [3], pc [3];
  logic [3:0]  be [3];
  logic        rdy [3], vo [3], err [3], bsy [3], tv [3];
  logic [31:0] rd [3], tpc [3], ta [3], td [3];

  dm_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(2)) u_w2 (
    .clk(clk), .reset(rst[0]), .req_valid(rv[0]), .req_ready(rdy[0]), .req_we(we[0]),
    .req_addr(addr[0]), .req_be(be[0]), .req_wdata(wd[0]), .req_pc(pc[0]),
    .resp_valid(vo[0]), .resp_ready(rr[0]), .resp_rdata(rd[0]), .resp_err(err[0]),
    .busy(bsy[0]), .trace_valid(tv[0]), .trace_pc(tpc[0]), .trace_addr(ta[0]), .trace_data(td[0]));
  dm_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .reset(rst[1]), .req_valid(rv[1]), .req_ready(rdy[1]), .req_we(we[1]),
    .req_addr(addr[1]), .req_be(be[1]), .req_wdata(wd[1]), .req_pc(pc[1]),
    .resp_valid(vo[1]), .resp_ready(rr[1]), .resp_rdata(rd[1]), .resp_err(err[1]),
    .busy(bsy[1]), .trace_valid(tv[1]), .trace_pc(tpc[1]), .trace_addr(ta[1]), .trace_data(td[1]));
  dm_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(3)) u_w3 (
    .clk(clk), .reset(rst[2]), .req_valid(rv[2]), .req_ready(rdy[2]), .req_we(we[2]),
    .req_addr(addr[2]), .req_be(be[2]), .req_wdata(wd[2]), .req_pc(pc[2]),
    .resp_valid(vo[2]), .resp_ready(rr[2]), .resp_rdata(rd[2]), .resp_err(err[2]),
    .busy(bsy[2]), .trace_valid(tv[2]), .trace_pc(tpc[2]), .trace_addr(ta[2]), .trace_data(td[2]));

  int n_chk = 0;
  int n_fail = 0;
  string last_trace = "";

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h, expected %08h", nm, act, exp);
    end
  endtask

  // One complete transaction. Checks latency, response, trace and, while the
  // response is held off, that outputs stay put and no new request is taken.
  task automatic txn(input int d, input logic w, input logic [31:0] a, input logic [3:0] b,
                     input logic [31:0] wdat, input logic [31:0] p, input int hold,
                     input bit intrude, input logic [31:0] e_rd, input logic e_err,
                     input logic [31:0] e_td, input string nm);
    int n;
    bit tr_seen;
    logic [31:0] t_pc, t_a, t_d;
    logic e_tr;
    e_tr = w && !e_err;
    @(negedge clk);
    chk({nm, " ready"}, 32'(rdy[d]), 32'd1);
    rv[d] = 1'b1; we[d] = w; addr[d] = a; be[d] = b; wd[d] = wdat; pc[d] = p; rr[d] = 1'b0;
    @(posedge clk); #1;
    rv[d] = 1'b0; we[d] = 1'($urandom); addr[d] = $urandom; be[d] = 4'($urandom);
    wd[d] = $urandom; pc[d] = $urandom;
    n = 0; tr_seen = 0; t_pc = 0; t_a = 0; t_d = 0;
    forever begin
      n++;
      @(negedge clk);
      if (tv[d]) begin
        tr_seen = 1; t_pc = tpc[d]; t_a = ta[d]; t_d = td[d];
        last_trace = $sformatf("@%08h: *%08h <= %08h", t_pc, t_a, t_d);
        $display("%s", last_trace);
      end
      if (vo[d] || n >= 40) break;
      @(posedge clk);
    end
    chk({nm, " latency"}, 32'(n), 32'(WC[d] + 1));
    chk({nm, " rdata"}, rd[d], e_rd);
    chk({nm, " err"}, 32'(err[d]), 32'(e_err));
    chk({nm, " trace seen"}, 32'(tr_seen), 32'(e_tr));
    if (e_tr) begin
      chk({nm, " trace pc"}, t_pc, p);
      chk({nm, " trace addr"}, t_a, a & ~32'd3);
      chk({nm, " trace data"}, t_d, e_td);
    end
    if (intrude) begin
      rv[d] = 1'b1; we[d] = 1'b1; addr[d] = 32'h18; be[d] = 4'hF; wd[d] = 32'h99999999;
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); @(negedge clk);
      chk({nm, " hold valid"}, 32'(vo[d]), 32'd1);
      chk({nm, " hold rdata"}, rd[d], e_rd);
      chk({nm, " hold err"}, 32'(err[d]), 32'(e_err));
      chk({nm, " hold ready"}, 32'(rdy[d]), 32'd0);
      chk({nm, " hold trace"}, 32'(tv[d]), 32'd0);
    end
    rr[d] = 1'b1;
    @(posedge clk); @(negedge clk);
    rr[d] = 1'b0;
    rv[d] = 1'b0;
    chk({nm, " released valid"}, 32'(vo[d]), 32'd0);
    chk({nm, " released ready"}, 32'(rdy[d]), 32'd1);
    chk({nm, " released busy"}, 32'(bsy[d]), 32'd0);
  endtask

  function automatic bit legal(input logic [31:0] a, input logic [3:0] b);
    int sz, ls;
    sz = $countones(b);
    if (!(sz == 1 || sz == 2 || sz == 4)) return 0;
    ls = 0;
    while (!b[ls]) ls++;
    return (b == 4'(((1 << sz) - 1) << ls)) && (ls % sz == 0) && (int'(a[1:0]) == ls)
           && (a[31:2] < 30'(DEPTH));
  endfunction

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rd;
    logic        err;
    logic [31:0] td;
  } vec_t;

  vec_t vecs [15];
  logic [31:0] mdl [DEPTH];

  initial begin
    vecs[0]  = '{1'b1, 32'h10,  4'hF, 32'hDEADBEEF, 32'h0,        1'b0, 32'hDEADBEEF};
    vecs[1]  = '{1'b0, 32'h10,  4'hF, 32'h0,        32'hDEADBEEF, 1'b0, 32'h0};
    vecs[2]  = '{1'b1, 32'h13,  4'h8, 32'h11000000, 32'h0,        1'b0, 32'h11ADBEEF};
    vecs[3]  = '{1'b0, 32'h10,  4'hF, 32'h0,        32'h11ADBEEF, 1'b0, 32'h0};
    vecs[4]  = '{1'b1, 32'h10,  4'h3, 32'h00002222, 32'h0,        1'b0, 32'h11AD2222};
    vecs[5]  = '{1'b0, 32'h10,  4'hF, 32'h0,        32'h11AD2222, 1'b0, 32'h0};
    vecs[6]  = '{1'b1, 32'h12,  4'hF, 32'h55555555, 32'h0,        1'b1, 32'h0};
    vecs[7]  = '{1'b0, 32'h10,  4'hF, 32'h0,        32'h11AD2222, 1'b0, 32'h0};
    vecs[8]  = '{1'b0, 32'h100, 4'hF, 32'h0,        32'h0,        1'b1, 32'h0};
    vecs[9]  = '{1'b1, 32'h14,  4'h6, 32'h77777777, 32'h0,        1'b1, 32'h0};
    vecs[10] = '{1'b0, 32'h14,  4'hF, 32'h0,        32'h0,        1'b0, 32'h0};
    vecs[11] = '{1'b0, 32'h11,  4'h2, 32'h0,        32'h11AD2222, 1'b0, 32'h0};
    vecs[12] = '{1'b0, 32'h11,  4'h1, 32'h0,        32'h0,        1'b1, 32'h0};
    vecs[13] = '{1'b1, 32'hFC,  4'hF, 32'h12345678, 32'h0,        1'b0, 32'h12345678};
    vecs[14] = '{1'b0, 32'hFC,  4'hF, 32'h0,        32'h12345678, 1'b0, 32'h0};

    for (int d = 0; d < 3; d++) begin
      rst[d] = 1'b1; rv[d] = 1'b0; we[d] = 1'b0; rr[d] = 1'b0;
      addr[d] = '0; wd[d] = '0; pc[d] = '0; be[d] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("reset ready %0d", d), 32'(rdy[d]), 32'd1);
      chk($sformatf("reset valid %0d", d), 32'(vo[d]), 32'd0);
      chk($sformatf("reset rdata %0d", d), rd[d], 32'd0);
      chk($sformatf("reset err %0d", d), 32'(err[d]), 32'd0);
      chk($sformatf("reset busy %0d", d), 32'(bsy[d]), 32'd0);
      rst[d] = 1'b0;
    end

    // Directed table on the 2-wait-state instance.
    for (int i = 0; i < 15; i++) begin
      txn(0, vecs[i].we, vecs[i].addr, vecs[i].be, vecs[i].wdata, 32'h3000 + 32'(4 * i),
          (i % 3 == 1) ? 1 : 0, 1'b0, vecs[i].rd, vecs[i].err, vecs[i].td, $sformatf("vec%0d", i));
      if (i == 0) begin
        n_chk++;
        if (last_trace != "@00003000: *00000010 <= deadbeef") begin
          n_fail++;
          $display("FAIL trace text: got '%s', expected '@00003000: *00000010 <= deadbeef'", last_trace);
        end
      end
    end

    // Backpressure with a competing store presented throughout RESP.
    txn(0, 1'b0, 32'h10, 4'hF, 32'h0, 32'h3100, 5, 1'b1, 32'h11AD2222, 1'b0, 32'h0, "bp");
    @(posedge clk); @(negedge clk);
    chk("bp not accepted", 32'(bsy[0]), 32'd0);
    txn(0, 1'b0, 32'h18, 4'hF, 32'h0, 32'h3104, 0, 1'b0, 32'h0, 1'b0, 32'h0, "bp word");

    // Reset in WAIT aborts a store on the 3-wait-state instance.
    @(negedge clk);
    rv[2] = 1'b1; we[2] = 1'b1; addr[2] = 32'h20; be[2] = 4'hF; wd[2] = 32'hCAFEF00D; pc[2] = 32'h4000;
    @(posedge clk); #1;
    rv[2] = 1'b0;
    @(negedge clk);
    chk("abort busy before", 32'(bsy[2]), 32'd1);
    rst[2] = 1'b1;
    @(posedge clk); @(negedge clk);
    rst[2] = 1'b0;
    chk("abort ready", 32'(rdy[2]), 32'd1);
    chk("abort valid", 32'(vo[2]), 32'd0);
    chk("abort rdata", rd[2], 32'd0);
    chk("abort err", 32'(err[2]), 32'd0);
    chk("abort busy", 32'(bsy[2]), 32'd0);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); @(negedge clk);
      chk("abort quiet", 32'({tv[2], vo[2]}), 32'd0);
    end
    // Reset beats an accept on the same edge.
    rv[2] = 1'b1; rst[2] = 1'b1;
    @(posedge clk); @(negedge clk);
    rv[2] = 1'b0; rst[2] = 1'b0;
    chk("reset over accept busy", 32'(bsy[2]), 32'd0);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); @(negedge clk);
      chk("reset over accept quiet", 32'({tv[2], vo[2]}), 32'd0);
    end
    txn(2, 1'b0, 32'h20, 4'hF, 32'h0, 32'h4004, 0, 1'b0, 32'h0, 1'b0, 32'h0, "abort word");

    // Random traffic on the zero-wait instance against a word-array model.
    for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
    for (int i = 0; i < 150; i++) begin
      logic [3:0] bes [8];
      logic [3:0] b;
      logic [31:0] a, wdat, e_rd, mask, e_td;
      logic w, ok;
      int sel, off, ls;
      bes = '{4'hF, 4'h3, 4'hC, 4'h1, 4'h2, 4'h4, 4'h8, 4'h6};
      sel = $urandom_range(0, 8);
      b = (sel == 8) ? 4'($urandom) : bes[sel];
      off = $urandom_range(0, 3);
      if (b != 0 && ($urandom % 4) != 0) begin
        ls = 0;
        while (!b[ls]) ls++;
        off = ls;
      end
      a = 32'($urandom_range(0, DEPTH + 3)) * 4 + 32'(off);
      w = 1'($urandom);
      wdat = $urandom;
      ok = legal(a, b);
      e_rd = 0; e_td = 0;
      if (ok) begin
        mask = {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
        if (w) begin
          mdl[a[31:2]] = (mdl[a[31:2]] & ~mask) | (wdat & mask);
          e_td = mdl[a[31:2]];
        end else begin
          e_rd = mdl[a[31:2]];
        end
      end
      txn(1, w, a, b, wdat, $urandom, $urandom_range(0, 2), 1'b0, e_rd, !ok, e_td,
          $sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
